cnn_kernel_ctrl: RTL

CNN_KERNEL_CTRL -- requirements
Module: cnn_kernel_ctrl

---
 rtl/cnn_kernel_ctrl_pkg.sv | 28 ++
 rtl/cnn_ctrl_watchdog.sv | 36 +++
 rtl/cnn_kernel_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cnn_kernel_ctrl_pkg.sv
// Shared CNN core definitions: kernel geometry/data widths, controller
// defaults and the controller FSM state encoding.
package cnn_kernel_ctrl_pkg;

    // Kernel geometry and datapath widths used across the CNN core.
    localparam int unsigned CNN_KERNEL_W    = 3;
    localparam int unsigned CNN_KERNEL_H    = 3;
    localparam int unsigned CNN_DATA_W      = 8;
    localparam int unsigned CNN_WGT_W       = 8;

    // Controller defaults.
    localparam int unsigned CNN_CNT_BW_DEF  = 16;
    localparam int unsigned CNN_LATENCY_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } cnn_ctrl_state_e;

    // Width of a counter that must hold LATENCY+2.
    function automatic int unsigned cnn_wd_width(input int unsigned lat);
        return $clog2(lat + 3);
    endfunction

endpackage

// File: rtl/cnn_ctrl_watchdog.sv
// DRAIN watchdog: down-counter loaded with LATENCY+2 on load_i, decremented
// on every tick_i cycle. expire_o flags the last allowed tick cycle.
// Ports: clk, reset (sync, active-high), load_i, tick_i, expire_o.
module cnn_ctrl_watchdog
    import cnn_kernel_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = CNN_LATENCY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic tick_i,
    output logic expire_o
);
    localparam int unsigned W    = cnn_wd_width(LATENCY);
    localparam logic [W-1:0] INIT = W'(LATENCY + 2);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = INIT;
        else if (tick_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Count 1 means this is the (LATENCY+2)-th tick since load.
    assign expire_o = tick_i && (cnt_q == W'(1));

endmodule

// File: rtl/cnn_kernel_ctrl.sv
// CNN kernel controller: accepts a job of i_num_win windows, issues them to
// the kernel, counts returned results and reports done / sticky error.
// Ports: clk, reset (sync, active-high); i_run/i_num_win/i_abort job control;
// i_win_valid/o_win_ready upstream handshake; o_kernel_valid and
// o_kernel_soft_reset drive the kernel, i_kernel_valid is its result strobe;
// o_issue_cnt/o_ret_cnt progress; o_idle/o_done/o_err status.
module cnn_kernel_ctrl
    import cnn_kernel_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = CNN_LATENCY_DEF,
    parameter int unsigned CNT_BW  = CNN_CNT_BW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic [CNT_BW-1:0] i_num_win,
    input  logic              i_abort,
    input  logic              i_win_valid,
    output logic              o_win_ready,
    output logic              o_kernel_valid,
    output logic              o_kernel_soft_reset,
    input  logic              i_kernel_valid,
    output logic [CNT_BW-1:0] o_issue_cnt,
    output logic [CNT_BW-1:0] o_ret_cnt,
    output logic              o_idle,
    output logic              o_done,
    output logic              o_err
);
    cnn_ctrl_state_e   state_q, state_d;
    logic [CNT_BW-1:0] num_q, num_d;
    logic [CNT_BW-1:0] issue_q, issue_d;
    logic [CNT_BW-1:0] ret_q, ret_d;
    logic              err_q, err_d;
    logic              sr_q, sr_d;
    logic              done_q, idle_q;
    logic              win_ready, issue_fire, ret_ok, ret_bad, active;
    logic              wd_load, wd_expire;

    always_comb begin
        win_ready  = (state_q == ST_RUN) && (issue_q < num_q);
        issue_fire = i_win_valid && win_ready;
        active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        // A result only counts while a job is in flight and not all returned;
        // anything else is a protocol error and is not counted.
        ret_ok     = i_kernel_valid && active && (ret_q != num_q);
        ret_bad    = i_kernel_valid && !ret_ok;

        state_d = state_q;
        num_d   = num_q;
        issue_d = issue_q + CNT_BW'(issue_fire);
        ret_d   = ret_q + CNT_BW'(ret_ok);
        err_d   = err_q | ret_bad;
        sr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    num_d   = i_num_win;
                    issue_d = '0;
                    ret_d   = '0;
                    err_d   = ret_bad;
                    if (i_num_win == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CLEAR;
                        sr_d    = 1'b1;
                    end
                end
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (issue_fire && issue_d == num_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Completion in the final watchdog cycle still wins.
                if (ret_d == num_q) begin
                    state_d = ST_DONE;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (i_abort && (state_q inside {ST_CLEAR, ST_RUN, ST_DRAIN})) begin
            state_d = ST_IDLE;
            sr_d    = 1'b1;
            err_d   = err_q;
        end

        wd_load = (state_q != ST_DRAIN) && (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            issue_q <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
            sr_q    <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
            sr_q    <= sr_d;
            done_q  <= (state_d == ST_DONE);
            idle_q  <= (state_d == ST_IDLE);
        end
    end

    cnn_ctrl_watchdog #(.LATENCY(LATENCY)) u_wd (
        .clk      (clk),
        .reset    (reset),
        .load_i   (wd_load),
        .tick_i   (state_q == ST_DRAIN),
        .expire_o (wd_expire)
    );

    assign o_win_ready         = win_ready;
    assign o_kernel_valid      = issue_fire;
    assign o_kernel_soft_reset = sr_q;
    assign o_issue_cnt         = issue_q;
    assign o_ret_cnt           = ret_q;
    assign o_idle              = idle_q;
    assign o_done              = done_q;
    assign o_err               = err_q;

endmodule
